// File: rtl/mips_control_fsm.sv
// Multicycle MIPS control unit: state sequencer plus combinational decode of
// datapath strobes, with memory stalls, byte-lane enables and a multi-cycle mul/div wait.
module mips_control_fsm #(
    parameter int MULDIV_CYCLES = 1,
    parameter bit MEM_WAIT_EN   = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] func_code,
    input  logic [1:0] addr_lo,
    input  logic       waitrequest,
    input  logic       pc_is_zero,
    output logic [2:0] state,
    output logic       active,
    output logic       RegDst,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       MemtoReg,
    output logic       IRWrite,
    output logic       unsign,
    output logic       fixed_shift,
    output logic       hi_lo_write,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic [3:0] ALUctl,
    output logic [3:0] byteenable
);

    typedef enum logic [2:0] {
        FETCH         = 3'd0,
        DECODE        = 3'd1,
        EXECUTE       = 3'd2,
        MEMORY_ACCESS = 3'd3,
        WRITE_BACK    = 3'd4,
        MULDIV_WAIT   = 3'd5,
        HALTED        = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        CLS_NOP,
        CLS_R_ALU,
        CLS_I_ALU,
        CLS_JR,
        CLS_LOAD,
        CLS_STORE,
        CLS_MULDIV,
        CLS_HILO
    } class_t;

    localparam logic [3:0] ALU_ADD = 4'd0;
    localparam logic [3:0] ALU_AND = 4'd1;
    localparam logic [3:0] ALU_SUB = 4'd2;
    localparam logic [3:0] ALU_SLT = 4'd6;
    localparam logic [3:0] ALU_MUL = 4'd7;
    localparam logic [3:0] ALU_DIV = 4'd8;
    localparam logic [3:0] ALU_OR  = 4'd9;
    localparam logic [3:0] ALU_XOR = 4'd10;
    localparam logic [3:0] ALU_SLL = 4'd11;
    localparam logic [3:0] ALU_SRL = 4'd12;
    localparam logic [3:0] ALU_SRA = 4'd13;

    localparam logic [3:0] MULDIV_LOAD = 4'(MULDIV_CYCLES - 1);

    state_t     cur_state;
    logic [3:0] muldiv_cnt;
    class_t     cls;
    logic [3:0] alu_op;
    logic [1:0] exec_srcb;
    logic       unsign_op;
    logic       shift_op;
    logic [3:0] mem_be;
    logic       stall;

    assign state = cur_state;
    assign stall = MEM_WAIT_EN && waitrequest;

    // Instruction decode from the IR fields; only meaningful from EXECUTE onward.
    always_comb begin
        cls       = CLS_NOP;
        alu_op    = ALU_ADD;
        unsign_op = 1'b0;
        shift_op  = 1'b0;
        mem_be    = 4'b1111;
        if (opcode == 6'h00) begin
            case (func_code)
                6'h00: begin cls = CLS_R_ALU; alu_op = ALU_SLL; shift_op = 1'b1; end
                6'h02: begin cls = CLS_R_ALU; alu_op = ALU_SRL; shift_op = 1'b1; end
                6'h03: begin cls = CLS_R_ALU; alu_op = ALU_SRA; shift_op = 1'b1; end
                6'h04: begin cls = CLS_R_ALU; alu_op = ALU_SLL; end
                6'h06: begin cls = CLS_R_ALU; alu_op = ALU_SRL; end
                6'h07: begin cls = CLS_R_ALU; alu_op = ALU_SRA; end
                6'h08: cls = CLS_JR;
                6'h10, 6'h12: cls = CLS_R_ALU;
                6'h11, 6'h13: cls = CLS_HILO;
                6'h18: begin cls = CLS_MULDIV; alu_op = ALU_MUL; end
                6'h19: begin cls = CLS_MULDIV; alu_op = ALU_MUL; unsign_op = 1'b1; end
                6'h1A: begin cls = CLS_MULDIV; alu_op = ALU_DIV; end
                6'h1B: begin cls = CLS_MULDIV; alu_op = ALU_DIV; unsign_op = 1'b1; end
                6'h20, 6'h21: cls = CLS_R_ALU;
                6'h22: begin cls = CLS_R_ALU; alu_op = ALU_SUB; end
                6'h23: begin cls = CLS_R_ALU; alu_op = ALU_SUB; unsign_op = 1'b1; end
                6'h24: begin cls = CLS_R_ALU; alu_op = ALU_AND; end
                6'h25: begin cls = CLS_R_ALU; alu_op = ALU_OR;  end
                6'h26: begin cls = CLS_R_ALU; alu_op = ALU_XOR; end
                6'h2A: begin cls = CLS_R_ALU; alu_op = ALU_SLT; end
                6'h2B: begin cls = CLS_R_ALU; alu_op = ALU_SLT; unsign_op = 1'b1; end
                default: cls = CLS_NOP;
            endcase
        end else begin
            case (opcode)
                6'h08, 6'h09: cls = CLS_I_ALU;
                6'h0A: begin cls = CLS_I_ALU; alu_op = ALU_SLT; end
                6'h0B: begin cls = CLS_I_ALU; alu_op = ALU_SLT; unsign_op = 1'b1; end
                6'h0C: begin cls = CLS_I_ALU; alu_op = ALU_AND; end
                6'h0D: begin cls = CLS_I_ALU; alu_op = ALU_OR;  end
                6'h0E: begin cls = CLS_I_ALU; alu_op = ALU_XOR; end
                6'h0F: cls = CLS_I_ALU;
                6'h20, 6'h24: begin cls = CLS_LOAD; mem_be = 4'b0001 << addr_lo; end
                6'h21, 6'h25: begin cls = CLS_LOAD; mem_be = addr_lo[1] ? 4'b1100 : 4'b0011; end
                6'h22, 6'h23, 6'h26: cls = CLS_LOAD;
                6'h28: begin cls = CLS_STORE; mem_be = 4'b0001 << addr_lo; end
                6'h29: begin cls = CLS_STORE; mem_be = addr_lo[1] ? 4'b1100 : 4'b0011; end
                6'h2B: cls = CLS_STORE;
                default: cls = CLS_NOP;
            endcase
        end
        exec_srcb = (cls == CLS_I_ALU || cls == CLS_LOAD || cls == CLS_STORE) ? 2'd2 : 2'd0;
    end

    // Strobes are purely combinational from the current state and inputs; reset overrides all.
    always_comb begin
        RegDst      = 1'b0;
        RegWrite    = 1'b0;
        ALUSrcA     = 1'b1;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        MemtoReg    = 1'b0;
        IRWrite     = 1'b0;
        unsign      = 1'b0;
        fixed_shift = 1'b0;
        hi_lo_write = 1'b0;
        ALUSrcB     = 2'd0;
        PCSource    = 2'd0;
        ALUctl      = ALU_ADD;
        byteenable  = 4'b1111;
        case (cur_state)
            FETCH: begin
                if (pc_is_zero) begin
                    ALUSrcA = 1'b0;
                end else begin
                    MemRead = 1'b1;
                    ALUSrcA = 1'b0;
                    ALUSrcB = 2'd1;
                    PCWrite = !stall;
                end
            end
            DECODE: begin
                IRWrite = 1'b1;
                ALUSrcA = 1'b0;
                ALUSrcB = 2'd2;
            end
            EXECUTE: begin
                if (cls != CLS_NOP) begin
                    ALUSrcB     = exec_srcb;
                    ALUctl      = alu_op;
                    unsign      = unsign_op;
                    fixed_shift = shift_op;
                end
                if (cls == CLS_HILO || (cls == CLS_MULDIV && MULDIV_CYCLES == 1))
                    hi_lo_write = 1'b1;
            end
            MULDIV_WAIT: begin
                ALUSrcB     = exec_srcb;
                ALUctl      = alu_op;
                unsign      = unsign_op;
                fixed_shift = shift_op;
                hi_lo_write = (muldiv_cnt <= 4'd1);
            end
            MEMORY_ACCESS: begin
                case (cls)
                    CLS_R_ALU: begin RegWrite = 1'b1; RegDst = 1'b1; end
                    CLS_I_ALU: RegWrite = 1'b1;
                    CLS_JR:    begin PCSource = 2'd1; PCWriteCond = 1'b1; end
                    CLS_LOAD:  begin IorD = 1'b1; MemRead = 1'b1; byteenable = mem_be; end
                    CLS_STORE: begin IorD = 1'b1; MemWrite = 1'b1; byteenable = mem_be; end
                    default: ;
                endcase
            end
            WRITE_BACK: begin
                if (cls == CLS_LOAD) begin
                    RegWrite = 1'b1;
                    MemtoReg = 1'b1;
                end
            end
            default: ALUSrcA = 1'b0;
        endcase
        if (reset) begin
            RegDst      = 1'b0;
            RegWrite    = 1'b0;
            ALUSrcA     = 1'b0;
            PCWrite     = 1'b0;
            PCWriteCond = 1'b0;
            IorD        = 1'b0;
            MemRead     = 1'b0;
            MemWrite    = 1'b0;
            MemtoReg    = 1'b0;
            IRWrite     = 1'b0;
            unsign      = 1'b0;
            fixed_shift = 1'b0;
            hi_lo_write = 1'b0;
            ALUSrcB     = 2'd0;
            PCSource    = 2'd0;
            ALUctl      = ALU_ADD;
            byteenable  = 4'b0000;
        end
    end

    // Sequencer: HALTED is absorbing until reset; the counter only runs in MULDIV_WAIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cur_state  <= FETCH;
            muldiv_cnt <= 4'd0;
            active     <= 1'b1;
        end else begin
            case (cur_state)
                FETCH: begin
                    if (pc_is_zero) begin
                        cur_state <= HALTED;
                        active    <= 1'b0;
                    end else if (!stall) begin
                        cur_state <= DECODE;
                    end
                end
                DECODE: cur_state <= EXECUTE;
                EXECUTE: begin
                    case (cls)
                        CLS_NOP, CLS_HILO: cur_state <= FETCH;
                        CLS_MULDIV: begin
                            if (MULDIV_CYCLES == 1) begin
                                cur_state <= FETCH;
                            end else begin
                                muldiv_cnt <= MULDIV_LOAD;
                                cur_state  <= MULDIV_WAIT;
                            end
                        end
                        default: cur_state <= MEMORY_ACCESS;
                    endcase
                end
                MULDIV_WAIT: begin
                    if (muldiv_cnt <= 4'd1) begin
                        muldiv_cnt <= 4'd0;
                        cur_state  <= FETCH;
                    end else begin
                        muldiv_cnt <= muldiv_cnt - 4'd1;
                    end
                end
                MEMORY_ACCESS: begin
                    if (cls == CLS_LOAD) begin
                        if (!stall) cur_state <= WRITE_BACK;
                    end else if (cls == CLS_STORE) begin
                        if (!stall) cur_state <= FETCH;
                    end else begin
                        cur_state <= FETCH;
                    end
                end
                WRITE_BACK: cur_state <= FETCH;
                HALTED:     cur_state <= HALTED;
                default:    cur_state <= FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Cycle-scripted bench for mips_control_fsm: each driven cycle pushes its expected
// output vector to a scoreboard that a monitor pops and compares mid-cycle.
module tb_mips_control_fsm;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [5:0] opcode = 6'h00;
    logic [5:0] func_code = 6'h00;
    logic [1:0] addr_lo = 2'd0;
    logic       waitrequest = 1'b0;
    logic       pc_is_zero = 1'b0;
    logic [2:0] state;
    logic       active;
    logic       RegDst, RegWrite, ALUSrcA, PCWrite, PCWriteCond, IorD, MemRead;
    logic       MemWrite, MemtoReg, IRWrite, unsign, fixed_shift, hi_lo_write;
    logic [1:0] ALUSrcB, PCSource;
    logic [3:0] ALUctl, byteenable;

    mips_control_fsm #(.MULDIV_CYCLES(4), .MEM_WAIT_EN(1'b1)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .func_code(func_code),
        .addr_lo(addr_lo), .waitrequest(waitrequest), .pc_is_zero(pc_is_zero),
        .state(state), .active(active), .RegDst(RegDst), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
        .unsign(unsign), .fixed_shift(fixed_shift), .hi_lo_write(hi_lo_write),
        .ALUSrcB(ALUSrcB), .PCSource(PCSource), .ALUctl(ALUctl), .byteenable(byteenable)
    );

    always #5 clk = ~clk;

    localparam logic [12:0] S_REGDST   = 13'h1000;
    localparam logic [12:0] S_REGWRITE = 13'h0800;
    localparam logic [12:0] S_ALUSRCA  = 13'h0400;
    localparam logic [12:0] S_PCWRITE  = 13'h0200;
    localparam logic [12:0] S_PCWCOND  = 13'h0100;
    localparam logic [12:0] S_IORD     = 13'h0080;
    localparam logic [12:0] S_MEMREAD  = 13'h0040;
    localparam logic [12:0] S_MEMWRITE = 13'h0020;
    localparam logic [12:0] S_MEMTOREG = 13'h0010;
    localparam logic [12:0] S_IRWRITE  = 13'h0008;
    localparam logic [12:0] S_UNSIGN   = 13'h0004;
    localparam logic [12:0] S_FSHIFT   = 13'h0002;
    localparam logic [12:0] S_HILO     = 13'h0001;

    typedef struct {
        string       tag;
        logic [28:0] exp;
    } sb_t;

    sb_t sb_q[$];
    int  tests_run = 0;
    int  tests_failed = 0;

    logic [5:0] pend_op = 6'h00;
    logic [5:0] pend_fn = 6'h00;
    logic [1:0] pend_alo = 2'd0;
    logic       pend_reset = 1'b1;
    logic       pend_pcz = 1'b0;

    function automatic logic [28:0] mk(input logic [2:0] st, input logic act,
                                       input logic [12:0] s, input logic [1:0] srcb,
                                       input logic [1:0] pcs, input logic [3:0] ctl,
                                       input logic [3:0] be);
        return {st, act, s, srcb, pcs, ctl, be};
    endfunction

    logic [28:0] V_RST, V_F, V_FS, V_D, V_MEM_R, V_MEM_I, V_WB;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic setInstr(input logic [5:0] op, input logic [5:0] fn, input logic [1:0] alo);
        pend_op  = op;
        pend_fn  = fn;
        pend_alo = alo;
    endtask

    // One clock cycle: drive pending inputs after the falling edge and queue what this cycle must show.
    task automatic applyStimulus(input string tag, input logic wr, input logic [28:0] exp);
        sb_t e;
        @(negedge clk);
        opcode      = pend_op;
        func_code   = pend_fn;
        addr_lo     = pend_alo;
        reset       = pend_reset;
        pc_is_zero  = pend_pcz;
        waitrequest = wr;
        e.tag = tag;
        e.exp = exp;
        sb_q.push_back(e);
    endtask

    task automatic fetchDecode(input string tag);
        applyStimulus({tag, "_f"}, 1'b0, V_F);
        applyStimulus({tag, "_d"}, 1'b0, V_D);
    endtask

    initial begin
        sb_t e;
        logic [28:0] obs;
        forever begin
            @(negedge clk);
            #2;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                obs = {state, active, RegDst, RegWrite, ALUSrcA, PCWrite, PCWriteCond, IorD,
                       MemRead, MemWrite, MemtoReg, IRWrite, unsign, fixed_shift, hi_lo_write,
                       ALUSrcB, PCSource, ALUctl, byteenable};
                checkOutput(e.tag, {3'b000, obs}, {3'b000, e.exp});
            end
        end
    end

    initial begin
        V_RST   = mk(3'd0, 1'b1, 13'h0, 2'd0, 2'd0, 4'd0, 4'h0);
        V_F     = mk(3'd0, 1'b1, S_MEMREAD | S_PCWRITE, 2'd1, 2'd0, 4'd0, 4'hF);
        V_FS    = mk(3'd0, 1'b1, S_MEMREAD, 2'd1, 2'd0, 4'd0, 4'hF);
        V_D     = mk(3'd1, 1'b1, S_IRWRITE, 2'd2, 2'd0, 4'd0, 4'hF);
        V_MEM_R = mk(3'd3, 1'b1, S_ALUSRCA | S_REGWRITE | S_REGDST, 2'd0, 2'd0, 4'd0, 4'hF);
        V_MEM_I = mk(3'd3, 1'b1, S_ALUSRCA | S_REGWRITE, 2'd0, 2'd0, 4'd0, 4'hF);
        V_WB    = mk(3'd4, 1'b1, S_ALUSRCA | S_REGWRITE | S_MEMTOREG, 2'd0, 2'd0, 4'd0, 4'hF);

        applyStimulus("reset0", 1'b0, V_RST);
        applyStimulus("reset1", 1'b1, V_RST);
        pend_reset = 1'b0;

        setInstr(6'h00, 6'h21, 2'd0);
        fetchDecode("addu");
        applyStimulus("addu_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd0, 2'd0, 4'd0, 4'hF));
        applyStimulus("addu_ma", 1'b0, V_MEM_R);

        setInstr(6'h23, 6'h00, 2'd0);
        fetchDecode("lw");
        applyStimulus("lw_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd2, 2'd0, 4'd0, 4'hF));
        for (int i = 0; i < 3; i++)
            applyStimulus($sformatf("lw_ma%0d", i), (i < 2),
                          mk(3'd3, 1'b1, S_ALUSRCA | S_IORD | S_MEMREAD, 2'd0, 2'd0, 4'd0, 4'hF));
        applyStimulus("lw_wb", 1'b0, V_WB);

        setInstr(6'h28, 6'h00, 2'd2);
        fetchDecode("sb2");
        applyStimulus("sb2_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd2, 2'd0, 4'd0, 4'hF));
        applyStimulus("sb2_ma", 1'b0, mk(3'd3, 1'b1, S_ALUSRCA | S_IORD | S_MEMWRITE, 2'd0, 2'd0, 4'd0, 4'b0100));

        setInstr(6'h28, 6'h00, 2'd3);
        fetchDecode("sb3");
        applyStimulus("sb3_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd2, 2'd0, 4'd0, 4'hF));
        applyStimulus("sb3_ma", 1'b0, mk(3'd3, 1'b1, S_ALUSRCA | S_IORD | S_MEMWRITE, 2'd0, 2'd0, 4'd0, 4'b1000));

        setInstr(6'h29, 6'h00, 2'd2);
        fetchDecode("sh2");
        applyStimulus("sh2_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd2, 2'd0, 4'd0, 4'hF));
        applyStimulus("sh2_ma", 1'b0, mk(3'd3, 1'b1, S_ALUSRCA | S_IORD | S_MEMWRITE, 2'd0, 2'd0, 4'd0, 4'b1100));

        setInstr(6'h21, 6'h00, 2'd0);
        fetchDecode("lh0");
        applyStimulus("lh0_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd2, 2'd0, 4'd0, 4'hF));
        applyStimulus("lh0_ma", 1'b0, mk(3'd3, 1'b1, S_ALUSRCA | S_IORD | S_MEMREAD, 2'd0, 2'd0, 4'd0, 4'b0011));
        applyStimulus("lh0_wb", 1'b0, V_WB);

        // waitrequest only matters in FETCH and load/store MEMORY_ACCESS
        setInstr(6'h00, 6'h23, 2'd0);
        applyStimulus("subu_fs", 1'b1, V_FS);
        applyStimulus("subu_f", 1'b0, V_F);
        applyStimulus("subu_d", 1'b1, V_D);
        applyStimulus("subu_ex", 1'b1, mk(3'd2, 1'b1, S_ALUSRCA | S_UNSIGN, 2'd0, 2'd0, 4'd2, 4'hF));
        applyStimulus("subu_ma", 1'b1, V_MEM_R);

        setInstr(6'h00, 6'h00, 2'd0);
        fetchDecode("sll");
        applyStimulus("sll_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA | S_FSHIFT, 2'd0, 2'd0, 4'd11, 4'hF));
        applyStimulus("sll_ma", 1'b0, V_MEM_R);

        setInstr(6'h0B, 6'h00, 2'd0);
        fetchDecode("sltiu");
        applyStimulus("sltiu_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA | S_UNSIGN, 2'd2, 2'd0, 4'd6, 4'hF));
        applyStimulus("sltiu_ma", 1'b0, V_MEM_I);

        setInstr(6'h00, 6'h08, 2'd0);
        fetchDecode("jr");
        applyStimulus("jr_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd0, 2'd0, 4'd0, 4'hF));
        applyStimulus("jr_ma", 1'b1, mk(3'd3, 1'b1, S_ALUSRCA | S_PCWCOND, 2'd0, 2'd1, 4'd0, 4'hF));

        setInstr(6'h00, 6'h11, 2'd0);
        fetchDecode("mthi");
        applyStimulus("mthi_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA | S_HILO, 2'd0, 2'd0, 4'd0, 4'hF));

        setInstr(6'h00, 6'h1B, 2'd0);
        fetchDecode("divu");
        applyStimulus("divu_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA | S_UNSIGN, 2'd0, 2'd0, 4'd8, 4'hF));
        applyStimulus("divu_w1", 1'b1, mk(3'd5, 1'b1, S_ALUSRCA | S_UNSIGN, 2'd0, 2'd0, 4'd8, 4'hF));
        applyStimulus("divu_w2", 1'b0, mk(3'd5, 1'b1, S_ALUSRCA | S_UNSIGN, 2'd0, 2'd0, 4'd8, 4'hF));
        applyStimulus("divu_w3", 1'b0, mk(3'd5, 1'b1, S_ALUSRCA | S_UNSIGN | S_HILO, 2'd0, 2'd0, 4'd8, 4'hF));

        setInstr(6'h3F, 6'h00, 2'd0);
        fetchDecode("nop");
        applyStimulus("nop_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd0, 2'd0, 4'd0, 4'hF));

        setInstr(6'h2B, 6'h00, 2'd0);
        fetchDecode("sw");
        applyStimulus("sw_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd2, 2'd0, 4'd0, 4'hF));
        applyStimulus("sw_ma", 1'b1, mk(3'd3, 1'b1, S_ALUSRCA | S_IORD | S_MEMWRITE, 2'd0, 2'd0, 4'd0, 4'hF));
        pend_reset = 1'b1;
        applyStimulus("sw_rst", 1'b1, V_RST);
        pend_reset = 1'b0;
        fetchDecode("sw_again");
        applyStimulus("sw2_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd2, 2'd0, 4'd0, 4'hF));
        applyStimulus("sw2_ma", 1'b0, mk(3'd3, 1'b1, S_ALUSRCA | S_IORD | S_MEMWRITE, 2'd0, 2'd0, 4'd0, 4'hF));

        // pc_is_zero wins over a simultaneous stall and parks the FSM in HALTED
        pend_pcz = 1'b1;
        applyStimulus("halt_f", 1'b1, mk(3'd0, 1'b1, 13'h0, 2'd0, 2'd0, 4'd0, 4'hF));
        pend_pcz = 1'b0;
        applyStimulus("halted0", 1'b0, mk(3'd6, 1'b0, 13'h0, 2'd0, 2'd0, 4'd0, 4'hF));
        applyStimulus("halted1", 1'b1, mk(3'd6, 1'b0, 13'h0, 2'd0, 2'd0, 4'd0, 4'hF));
        pend_reset = 1'b1;
        applyStimulus("halt_rst", 1'b0, V_RST);
        pend_reset = 1'b0;
        setInstr(6'h00, 6'h21, 2'd0);
        fetchDecode("restart");
        applyStimulus("restart_ex", 1'b0, mk(3'd2, 1'b1, S_ALUSRCA, 2'd0, 2'd0, 4'd0, 4'hF));

        @(negedge clk);
        #4;
        checkOutput("sb_drain", sb_q.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
